// File: rtl/key_event_encoder.sv
// Converts the debounced key-state vector into a stream of press/release events.
// A round-robin scanner checks one key per cycle against its last reported state and queues changes in a FIFO.
module key_event_encoder #(
  parameter int unsigned KEYS       = 89,
  parameter int unsigned INDEX_W    = 7,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [KEYS-1:0]               keys_i,
  input  logic                          scan_en_i,
  output logic                          evt_valid_o,
  input  logic                          evt_ready_i,
  output logic [INDEX_W:0]              evt_data_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          scan_wrap_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [KEYS-1:0]    r_shadow;
  logic [INDEX_W-1:0] r_idx;
  logic               r_wrap;
  logic [INDEX_W:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;

  logic w_key;
  logic w_mismatch;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_adv;
  logic w_last;

  always_comb begin
    w_key      = keys_i[r_idx];
    w_mismatch = (w_key != r_shadow[r_idx]);
    // Full uses the registered count, so a same-cycle pop never frees room for a push.
    w_full     = (r_count == CW'(FIFO_DEPTH));
    w_push     = scan_en_i && w_mismatch && !w_full;
    w_adv      = scan_en_i && (!w_mismatch || !w_full);
    w_pop      = (r_count != '0) && evt_ready_i;
    w_last     = (r_idx == INDEX_W'(KEYS - 1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_shadow <= '1;
      r_idx    <= '0;
      r_wrap   <= 1'b0;
    end else begin
      r_wrap <= w_adv && w_last;
      if (w_adv) begin
        r_idx <= w_last ? '0 : r_idx + 1'b1;
      end
      if (w_push) begin
        r_shadow[r_idx] <= w_key;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {~w_key, r_idx};
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_comb begin
    evt_valid_o  = (r_count != '0);
    evt_data_o   = evt_valid_o ? r_mem[r_rd_ptr] : '0;
    fifo_count_o = r_count;
    scan_wrap_o  = r_wrap;
  end

endmodule

// File: tb/tb_key_event_encoder.sv
// Directed bench for key_event_encoder: expected events queue up as keys change
// and are compared in order as the consumer accepts them.
module tb_key_event_encoder;

  logic          clk = 1'b0;
  logic          rst;
  logic [88:0]   keys;
  logic          scan_en;
  logic          evt_valid;
  logic          evt_ready;
  logic [7:0]    evt_data;
  logic [3:0]    fifo_count;
  logic          scan_wrap;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sb [$];

  key_event_encoder #(.KEYS(89), .INDEX_W(7), .FIFO_DEPTH(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .keys_i      (keys),
    .scan_en_i   (scan_en),
    .evt_valid_o (evt_valid),
    .evt_ready_i (evt_ready),
    .evt_data_o  (evt_data),
    .fifo_count_o(fifo_count),
    .scan_wrap_o (scan_wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_wrap();
    int n;
    for (n = 0; n < 200; n++) begin
      tick(1);
      if (scan_wrap) break;
    end
    check("wrap_timeout", {31'd0, scan_wrap}, 32'd1);
  endtask

  task automatic wait_count(input string tag, input int c, input int lim);
    for (int n = 0; n < lim; n++) begin
      if (fifo_count == 4'(c)) break;
      tick(1);
    end
    check(tag, {28'd0, fifo_count}, c);
  endtask

  task automatic wait_drain(input string tag, input int lim);
    for (int n = 0; n < lim; n++) begin
      if (sb.size() == 0 && fifo_count == 4'd0) break;
      tick(1);
    end
    check(tag, {31'd0, (sb.size() == 0 && fifo_count == 4'd0)}, 32'd1);
  endtask

  // Consumer side: every accepted event must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_evt", {24'd0, evt_data}, 32'hFFFF_FFFF);
      end else begin
        check("evt", {24'd0, evt_data}, {24'd0, sb.pop_front()});
      end
    end
  end

  initial begin
    int first_wrap;
    int second_wrap;
    int n_wrap;
    logic saw_valid;

    rst = 1'b1; keys = '1; scan_en = 1'b1; evt_ready = 1'b1;
    tick(2);
    rst = 1'b0;
    check("rst_valid", {31'd0, evt_valid}, 0);
    check("rst_count", {28'd0, fifo_count}, 0);
    check("rst_data",  {24'd0, evt_data}, 0);
    check("rst_wrap",  {31'd0, scan_wrap}, 0);

    // Idle keys: no events, wrap every 89 cycles.
    first_wrap = 0; second_wrap = 0; n_wrap = 0; saw_valid = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      tick(1);
      if (evt_valid) saw_valid = 1'b1;
      if (scan_wrap) begin
        n_wrap++;
        if (n_wrap == 1) first_wrap = i;
        if (n_wrap == 2) second_wrap = i;
      end
    end
    check("idle_valid", {31'd0, saw_valid}, 0);
    check("wrap_count", n_wrap, 2);
    check("wrap_first", first_wrap, 89);
    check("wrap_period", second_wrap - first_wrap, 89);

    // Single key press at scan index 0: event appears 6 cycles later.
    wait_wrap();
    keys[5] = 1'b0;
    sb.push_back(8'h85);
    tick(5);
    check("k5_early", {31'd0, evt_valid}, 0);
    tick(1);
    check("k5_valid", {31'd0, evt_valid}, 1);
    check("k5_data",  {24'd0, evt_data}, 32'h85);
    wait_drain("k5_press_drain", 200);
    keys[5] = 1'b1;
    sb.push_back(8'h05);
    wait_drain("k5_release_drain", 200);

    // All keys pressed with consumer stalled: FIFO saturates, scanner stalls.
    wait_wrap();
    evt_ready = 1'b0;
    keys = '0;
    for (int i = 0; i < 89; i++) sb.push_back({1'b1, 7'(i)});
    tick(20);
    check("full_count", {28'd0, fifo_count}, 8);
    check("full_head",  {24'd0, evt_data}, 32'h80);
    tick(5);
    check("full_hold_count", {28'd0, fifo_count}, 8);
    check("full_hold_head",  {24'd0, evt_data}, 32'h80);

    // Pop while full: stalled push is rejected this cycle, lands the next.
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    check("popfull_count", {28'd0, fifo_count}, 7);
    tick(1);
    check("retry_count", {28'd0, fifo_count}, 8);
    check("retry_head",  {24'd0, evt_data}, 32'h81);
    evt_ready = 1'b1;
    wait_drain("all_press_drain", 400);

    // Scanner disabled while key 40 changes; queued events still drain.
    wait_wrap();
    evt_ready = 1'b0;
    keys[0] = 1'b1; keys[1] = 1'b1; keys[2] = 1'b1;
    sb.push_back(8'h00); sb.push_back(8'h01); sb.push_back(8'h02);
    wait_count("queued3", 3, 50);
    scan_en = 1'b0;
    keys[40] = 1'b1;
    tick(3);
    check("dis_count", {28'd0, fifo_count}, 3);
    evt_ready = 1'b1;
    tick(100);
    check("dis_valid", {31'd0, evt_valid}, 0);
    check("dis_count_empty", {28'd0, fifo_count}, 0);
    check("dis_sb_empty", sb.size(), 0);
    sb.push_back(8'h28);
    scan_en = 1'b1;
    wait_drain("k40_drain", 200);

    // Release every remaining pressed key.
    wait_wrap();
    keys = '1;
    for (int i = 3; i < 89; i++) if (i != 40) sb.push_back({1'b0, 7'(i)});
    wait_drain("release_drain", 400);

    // Reset with events pending: they vanish and held key 3 is re-reported.
    wait_wrap();
    evt_ready = 1'b0;
    keys[3] = 1'b0; keys[10] = 1'b0; keys[20] = 1'b0; keys[30] = 1'b0;
    wait_count("queued4", 4, 60);
    rst = 1'b1;
    keys = '1;
    keys[3] = 1'b0;
    tick(1);
    rst = 1'b0;
    check("mid_rst_valid", {31'd0, evt_valid}, 0);
    check("mid_rst_count", {28'd0, fifo_count}, 0);
    check("mid_rst_data",  {24'd0, evt_data}, 0);
    sb.push_back(8'h83);
    evt_ready = 1'b1;
    wait_drain("k3_rereport_drain", 200);
    tick(100);
    check("final_count", {28'd0, fifo_count}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
